readout_word_buffer: RTL and testbench



---
 rtl/readout_pkg.sv | 9 +
 rtl/readout_buffer_ram.sv | 43 ++++
 rtl/readout_word_buffer.sv | 160 ++++++++++++++++
 tb/tb_readout_word_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// rtl/readout_pkg.sv - shared readout word width, lost-counter width and word type
package readout_pkg;

  localparam int READOUT_WORD_WIDTH = 32;
  localparam int LOST_COUNT_WIDTH   = 8;

  typedef logic [READOUT_WORD_WIDTH-1:0] readout_word_t;

endpackage

// File: rtl/readout_buffer_ram.sv
// rtl/readout_buffer_ram.sv - simple dual-port RAM, synchronous write, registered read
module readout_buffer_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Write-through so a word written into the head slot is visible right after the edge.
  always_comb begin
    rd_data_d = mem[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data_d = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/readout_word_buffer.sv
// rtl/readout_word_buffer.sv - FWFT elastic buffer between readout arbiter and SRAM FIFO
// Optional high-water mark register enabled by READOUT_BUFFER_MAX_LEVEL_EN.
import readout_pkg::*;

module readout_word_buffer #(
  parameter int DATA_WIDTH      = READOUT_WORD_WIDTH,
  parameter int DEPTH_LOG2      = 4,
  parameter int NEAR_FULL_LEVEL = 12
) (
  input  logic                        BUS_CLK,
  input  logic                        BUS_RST,
  input  logic                        WRITE_IN,
  input  logic [DATA_WIDTH-1:0]       DATA_IN,
  output logic                        READY_OUT,
  input  logic                        FIFO_READ_NEXT,
  output logic                        FIFO_EMPTY,
  output logic [DATA_WIDTH-1:0]       FIFO_DATA,
  output logic                        FIFO_NEAR_FULL,
  output logic                        FIFO_FULL,
  output logic [DEPTH_LOG2:0]         WORD_COUNT,
  input  logic                        CLEAR_ERR,
  output logic                        OVERFLOW_ERR,
  output logic                        READ_ERR,
  output logic [LOST_COUNT_WIDTH-1:0] LOST_COUNT,
  output logic [DEPTH_LOG2:0]         MAX_LEVEL
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT      = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] NEAR_FULL_CNT = NEAR_FULL_LEVEL[DEPTH_LOG2:0];
  localparam logic [LOST_COUNT_WIDTH-1:0] LOST_MAX = '1;

  logic [DEPTH_LOG2-1:0]       wr_ptr_d, wr_ptr_q;
  logic [DEPTH_LOG2-1:0]       rd_ptr_d, rd_ptr_q;
  logic [DEPTH_LOG2:0]         count_d, count_q;
  logic                        empty_d, empty_q;
  logic                        full_d, full_q;
  logic                        near_full_d, near_full_q;
  logic                        overflow_d, overflow_q;
  logic                        read_err_d, read_err_q;
  logic [LOST_COUNT_WIDTH-1:0] lost_d, lost_q;

  logic wr_acc, wr_rej, pop_acc, pop_bad;

  // Acceptance depends on registered count only: a full buffer rejects even with a same-cycle pop.
  assign wr_acc  = WRITE_IN & ~full_q;
  assign wr_rej  = WRITE_IN & full_q;
  assign pop_acc = FIFO_READ_NEXT & ~empty_q;
  assign pop_bad = FIFO_READ_NEXT & empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_acc && !pop_acc) begin
      count_d = count_q + 1'b1;
    end else if (pop_acc && !wr_acc) begin
      count_d = count_q - 1'b1;
    end
    empty_d     = (count_d == '0);
    full_d      = (count_d == FULL_CNT);
    near_full_d = (count_d >= NEAR_FULL_CNT);
  end

  // A new error event in the clearing cycle wins over CLEAR_ERR.
  always_comb begin
    overflow_d = CLEAR_ERR ? 1'b0 : overflow_q;
    read_err_d = CLEAR_ERR ? 1'b0 : read_err_q;
    lost_d     = CLEAR_ERR ? '0 : lost_q;
    if (wr_rej) begin
      overflow_d = 1'b1;
      if (CLEAR_ERR) begin
        lost_d = {{(LOST_COUNT_WIDTH-1){1'b0}}, 1'b1};
      end else if (lost_q != LOST_MAX) begin
        lost_d = lost_q + 1'b1;
      end
    end
    if (pop_bad) begin
      read_err_d = 1'b1;
    end
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      near_full_q <= 1'b0;
      overflow_q  <= 1'b0;
      read_err_q  <= 1'b0;
      lost_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      near_full_q <= near_full_d;
      overflow_q  <= overflow_d;
      read_err_q  <= read_err_d;
      lost_q      <= lost_d;
    end
  end

  // Reading at the next read pointer keeps the head word registered yet current after every pop.
  readout_buffer_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_LOG2)
  ) u_ram (
    .clk     (BUS_CLK),
    .rst     (BUS_RST),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (DATA_IN),
    .rd_addr (rd_ptr_d),
    .rd_data (FIFO_DATA)
  );

`ifdef READOUT_BUFFER_MAX_LEVEL_EN
  logic [DEPTH_LOG2:0] max_level_d, max_level_q;

  always_comb begin
    max_level_d = max_level_q;
    if (CLEAR_ERR) begin
      max_level_d = count_q;
    end else if (count_q > max_level_q) begin
      max_level_d = count_q;
    end
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      max_level_q <= '0;
    end else begin
      max_level_q <= max_level_d;
    end
  end

  assign MAX_LEVEL = max_level_q;
`else
  assign MAX_LEVEL = '0;
`endif

  assign READY_OUT      = ~full_q;
  assign FIFO_EMPTY     = empty_q;
  assign FIFO_FULL      = full_q;
  assign FIFO_NEAR_FULL = near_full_q;
  assign WORD_COUNT     = count_q;
  assign OVERFLOW_ERR   = overflow_q;
  assign READ_ERR       = read_err_q;
  assign LOST_COUNT     = lost_q;

endmodule

// File: tb/tb_readout_word_buffer.sv
// tb/tb_readout_word_buffer.sv - directed self-checking bench for readout_word_buffer
module tb_readout_word_buffer;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST;
  logic        WRITE_IN;
  logic [31:0] DATA_IN;
  logic        READY_OUT;
  logic        FIFO_READ_NEXT;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  logic        FIFO_NEAR_FULL;
  logic        FIFO_FULL;
  logic [4:0]  WORD_COUNT;
  logic        CLEAR_ERR;
  logic        OVERFLOW_ERR;
  logic        READ_ERR;
  logic [7:0]  LOST_COUNT;
  logic [4:0]  MAX_LEVEL;

  int tests_run = 0;
  int failed    = 0;

  always #10 BUS_CLK = ~BUS_CLK;

  readout_word_buffer dut (
    .BUS_CLK        (BUS_CLK),
    .BUS_RST        (BUS_RST),
    .WRITE_IN       (WRITE_IN),
    .DATA_IN        (DATA_IN),
    .READY_OUT      (READY_OUT),
    .FIFO_READ_NEXT (FIFO_READ_NEXT),
    .FIFO_EMPTY     (FIFO_EMPTY),
    .FIFO_DATA      (FIFO_DATA),
    .FIFO_NEAR_FULL (FIFO_NEAR_FULL),
    .FIFO_FULL      (FIFO_FULL),
    .WORD_COUNT     (WORD_COUNT),
    .CLEAR_ERR      (CLEAR_ERR),
    .OVERFLOW_ERR   (OVERFLOW_ERR),
    .READ_ERR       (READ_ERR),
    .LOST_COUNT     (LOST_COUNT),
    .MAX_LEVEL      (MAX_LEVEL)
  );

  task automatic tick;
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic idle_inputs;
    WRITE_IN       = 1'b0;
    DATA_IN        = '0;
    FIFO_READ_NEXT = 1'b0;
    CLEAR_ERR      = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    BUS_RST = 1'b1;
    tick();
    tick();
    BUS_RST = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    tests_run++; if (FIFO_EMPTY !== 1'b1) begin failed++; $display("FAIL reset_empty got %0b want 1", FIFO_EMPTY); end
    tests_run++; if (READY_OUT !== 1'b1) begin failed++; $display("FAIL reset_ready got %0b want 1", READY_OUT); end
    tests_run++; if (FIFO_FULL !== 1'b0 || FIFO_NEAR_FULL !== 1'b0) begin failed++; $display("FAIL reset_full got %0b/%0b want 0/0", FIFO_FULL, FIFO_NEAR_FULL); end
    tests_run++; if (WORD_COUNT !== 5'd0 || MAX_LEVEL !== 5'd0) begin failed++; $display("FAIL reset_count got %0d/%0d want 0/0", WORD_COUNT, MAX_LEVEL); end
    tests_run++; if (OVERFLOW_ERR !== 1'b0 || READ_ERR !== 1'b0 || LOST_COUNT !== 8'd0) begin failed++; $display("FAIL reset_errs got %0b/%0b/%0d want 0/0/0", OVERFLOW_ERR, READ_ERR, LOST_COUNT); end
    tests_run++; if (FIFO_DATA !== 32'd0) begin failed++; $display("FAIL reset_data got %h want 0", FIFO_DATA); end
  endtask

  task automatic test_single_word;
    WRITE_IN = 1'b1; DATA_IN = 32'hDEADBEEF;
    tick();
    idle_inputs();
    tests_run++; if (FIFO_EMPTY !== 1'b0 || FIFO_DATA !== 32'hDEADBEEF || WORD_COUNT !== 5'd1) begin failed++; $display("FAIL single_write got empty=%0b data=%h cnt=%0d want 0/deadbeef/1", FIFO_EMPTY, FIFO_DATA, WORD_COUNT); end
    FIFO_READ_NEXT = 1'b1;
    tick();
    idle_inputs();
    tests_run++; if (FIFO_EMPTY !== 1'b1 || WORD_COUNT !== 5'd0) begin failed++; $display("FAIL single_pop got empty=%0b cnt=%0d want 1/0", FIFO_EMPTY, WORD_COUNT); end
  endtask

  task automatic test_fill_overflow;
    for (int i = 0; i < 16; i++) begin
      WRITE_IN = 1'b1; DATA_IN = i;
      tick();
      tests_run++; if (WORD_COUNT !== 5'(i + 1) || FIFO_NEAR_FULL !== (i + 1 >= 12)) begin failed++; $display("FAIL fill_%0d got cnt=%0d nf=%0b want %0d/%0b", i, WORD_COUNT, FIFO_NEAR_FULL, i + 1, (i + 1 >= 12)); end
    end
    idle_inputs();
    tests_run++; if (FIFO_FULL !== 1'b1 || READY_OUT !== 1'b0) begin failed++; $display("FAIL fill_full got full=%0b ready=%0b want 1/0", FIFO_FULL, READY_OUT); end
    WRITE_IN = 1'b1; DATA_IN = 32'd99;
    tick();
    idle_inputs();
    tests_run++; if (OVERFLOW_ERR !== 1'b1 || LOST_COUNT !== 8'd1 || WORD_COUNT !== 5'd16) begin failed++; $display("FAIL overflow got ovf=%0b lost=%0d cnt=%0d want 1/1/16", OVERFLOW_ERR, LOST_COUNT, WORD_COUNT); end
    for (int i = 0; i < 16; i++) begin
      tests_run++; if (FIFO_DATA !== 32'(i) || FIFO_EMPTY !== 1'b0) begin failed++; $display("FAIL drain_%0d got data=%0d empty=%0b want %0d/0", i, FIFO_DATA, FIFO_EMPTY, i); end
      FIFO_READ_NEXT = 1'b1;
      tick();
    end
    idle_inputs();
    tests_run++; if (FIFO_EMPTY !== 1'b1 || WORD_COUNT !== 5'd0) begin failed++; $display("FAIL drain_empty got empty=%0b cnt=%0d want 1/0", FIFO_EMPTY, WORD_COUNT); end
  endtask

  task automatic test_full_write_pop;
    for (int i = 0; i < 16; i++) begin
      WRITE_IN = 1'b1; DATA_IN = 100 + i;
      tick();
    end
    WRITE_IN = 1'b1; DATA_IN = 32'd555; FIFO_READ_NEXT = 1'b1;
    tick();
    idle_inputs();
    tests_run++; if (WORD_COUNT !== 5'd15 || READY_OUT !== 1'b1 || LOST_COUNT !== 8'd2) begin failed++; $display("FAIL full_wr_pop got cnt=%0d ready=%0b lost=%0d want 15/1/2", WORD_COUNT, READY_OUT, LOST_COUNT); end
    for (int i = 1; i < 16; i++) begin
      tests_run++; if (FIFO_DATA !== 32'(100 + i)) begin failed++; $display("FAIL full_wr_pop_data_%0d got %0d want %0d", i, FIFO_DATA, 100 + i); end
      FIFO_READ_NEXT = 1'b1;
      tick();
    end
    idle_inputs();
    tests_run++; if (FIFO_EMPTY !== 1'b1) begin failed++; $display("FAIL full_wr_pop_empty got %0b want 1", FIFO_EMPTY); end
  endtask

  task automatic test_back_to_back;
    CLEAR_ERR = 1'b1;
    tick();
    idle_inputs();
    WRITE_IN = 1'b1; DATA_IN = 32'd0;
    tick();
    for (int i = 0; i < 100; i++) begin
      tests_run++; if (FIFO_DATA !== 32'(i) || WORD_COUNT !== 5'd1) begin failed++; $display("FAIL stream_%0d got data=%0d cnt=%0d want %0d/1", i, FIFO_DATA, WORD_COUNT, i); end
      WRITE_IN = (i < 99); DATA_IN = i + 1; FIFO_READ_NEXT = 1'b1;
      tick();
    end
    idle_inputs();
    tests_run++; if (FIFO_EMPTY !== 1'b1 || OVERFLOW_ERR !== 1'b0 || READ_ERR !== 1'b0 || LOST_COUNT !== 8'd0) begin failed++; $display("FAIL stream_end got empty=%0b ovf=%0b rerr=%0b lost=%0d want 1/0/0/0", FIFO_EMPTY, OVERFLOW_ERR, READ_ERR, LOST_COUNT); end
  endtask

  task automatic test_read_err_clear;
    FIFO_READ_NEXT = 1'b1;
    tick();
    idle_inputs();
    tests_run++; if (READ_ERR !== 1'b1 || FIFO_EMPTY !== 1'b1 || WORD_COUNT !== 5'd0) begin failed++; $display("FAIL pop_empty got rerr=%0b empty=%0b cnt=%0d want 1/1/0", READ_ERR, FIFO_EMPTY, WORD_COUNT); end
    WRITE_IN = 1'b1; DATA_IN = 32'h77; FIFO_READ_NEXT = 1'b1;
    tick();
    idle_inputs();
    tests_run++; if (FIFO_DATA !== 32'h77 || WORD_COUNT !== 5'd1) begin failed++; $display("FAIL wr_pop_empty got data=%h cnt=%0d want 77/1", FIFO_DATA, WORD_COUNT); end
    FIFO_READ_NEXT = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      WRITE_IN = 1'b1; DATA_IN = i;
      tick();
    end
    tick();
    idle_inputs();
    CLEAR_ERR = 1'b1;
    tick();
    idle_inputs();
    tests_run++; if (READ_ERR !== 1'b0 || OVERFLOW_ERR !== 1'b0 || LOST_COUNT !== 8'd0 || WORD_COUNT !== 5'd16) begin failed++; $display("FAIL clear got rerr=%0b ovf=%0b lost=%0d cnt=%0d want 0/0/0/16", READ_ERR, OVERFLOW_ERR, LOST_COUNT, WORD_COUNT); end
    WRITE_IN = 1'b1; DATA_IN = 32'h5;
    tick();
    CLEAR_ERR = 1'b1;
    tick();
    idle_inputs();
    tests_run++; if (LOST_COUNT !== 8'd1 || OVERFLOW_ERR !== 1'b1) begin failed++; $display("FAIL clear_vs_drop got lost=%0d ovf=%0b want 1/1", LOST_COUNT, OVERFLOW_ERR); end
    for (int i = 0; i < 300; i++) begin
      WRITE_IN = 1'b1; DATA_IN = i;
      tick();
    end
    idle_inputs();
    tests_run++; if (LOST_COUNT !== 8'd255) begin failed++; $display("FAIL lost_saturate got %0d want 255", LOST_COUNT); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      WRITE_IN = 1'b1; DATA_IN = 200 + i;
      tick();
    end
    idle_inputs();
    tick();
    tests_run++; if (WORD_COUNT !== 5'd7 || FIFO_DATA !== 32'd200) begin failed++; $display("FAIL pre_reset got cnt=%0d data=%0d want 7/200", WORD_COUNT, FIFO_DATA); end
`ifdef READOUT_BUFFER_MAX_LEVEL_EN
    tests_run++; if (MAX_LEVEL !== 5'd7) begin failed++; $display("FAIL max_level got %0d want 7", MAX_LEVEL); end
`endif
    #4;
    BUS_RST = 1'b1;
    #1;
    tests_run++; if (FIFO_EMPTY !== 1'b1 || WORD_COUNT !== 5'd0 || FIFO_DATA !== 32'd0 || READY_OUT !== 1'b1 || MAX_LEVEL !== 5'd0) begin failed++; $display("FAIL async_reset got empty=%0b cnt=%0d data=%0d ready=%0b max=%0d want 1/0/0/1/0", FIFO_EMPTY, WORD_COUNT, FIFO_DATA, READY_OUT, MAX_LEVEL); end
    tick();
    BUS_RST = 1'b0;
    WRITE_IN = 1'b1; DATA_IN = 32'hABC;
    tick();
    idle_inputs();
    tests_run++; if (FIFO_DATA !== 32'hABC || WORD_COUNT !== 5'd1 || MAX_LEVEL !== 5'd0) begin failed++; $display("FAIL post_reset got data=%h cnt=%0d max=%0d want abc/1/0", FIFO_DATA, WORD_COUNT, MAX_LEVEL); end
  endtask

  initial begin
    idle_inputs();
    BUS_RST = 1'b1;
    test_reset();
    test_single_word();
    test_fill_overflow();
    test_full_write_pop();
    test_back_to_back();
    test_read_err_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
